// File: rtl/simple_cpu_pkg.sv
// Shared definitions for the simple_cpu data bus: I/O register word addresses
// and the two-state bus responder FSM encoding.
package simple_cpu_pkg;

  localparam int unsigned IO_DATA_W      = 16;

  localparam int unsigned IO_ADDR_SW     = 0;
  localparam int unsigned IO_ADDR_LED    = 1;
  localparam int unsigned IO_ADDR_CHG    = 2;
  localparam int unsigned IO_ADDR_IRQ_EN = 3;

  typedef logic [0:0] bus_state_t;
  localparam bus_state_t BUS_IDLE = 1'b0;
  localparam bus_state_t BUS_ACK  = 1'b1;

endpackage

// File: rtl/io_port_responder_if.sv
// simple_cpu data-bus request/response bundle; the CPU core is the master,
// memory-mapped peripherals are slaves.
interface io_port_responder_if
  import simple_cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = 4
);
  logic                 bus_req;
  logic                 bus_we;
  logic [ADDR_W-1:0]    bus_addr;
  logic [IO_DATA_W-1:0] bus_wdata;
  logic                 bus_ready;
  logic [IO_DATA_W-1:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_ready, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_ready, bus_rdata
  );
endinterface

// File: rtl/io_debounce.sv
// Switch synchronizer plus optional tick-sampled debouncer (IO_PORT_DEBOUNCE_EN).
// deb_edge flags the bits of deb that change on the coming clock edge.
module io_debounce
  import simple_cpu_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IO_DATA_W-1:0] sw,
  output logic [IO_DATA_W-1:0] deb,
  output logic [IO_DATA_W-1:0] deb_edge
);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
    $error("io_debounce: DEBOUNCE_CYCLES must be at least 2");
  end

  logic [IO_DATA_W-1:0] sync1_q;
  logic [IO_DATA_W-1:0] sw_sync_q;
  logic [IO_DATA_W-1:0] deb_q, deb_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sw_sync_q <= '0;
    end else begin
      sync1_q   <= sw;
      sw_sync_q <= sync1_q;
    end
  end

`ifdef IO_PORT_DEBOUNCE_EN
  localparam int unsigned    CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0]     cnt_q;
  logic                 tick;
  logic [IO_DATA_W-1:0] sample_q;
  logic [IO_DATA_W-1:0] sample_prev_q;

  assign tick = (cnt_q == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      sample_q      <= '0;
      sample_prev_q <= '0;
    end else begin
      cnt_q <= tick ? '0 : cnt_q + 1'b1;
      if (tick) begin
        sample_q      <= sw_sync_q;
        sample_prev_q <= sample_q;
      end
    end
  end

  // A bit only moves once two consecutive tick samples agree, so a pulse
  // narrower than one tick period can never be seen twice.
  // NOTE: deb_d gets a default before any conditional update so no latch is inferred.
  always_comb begin
    deb_d = deb_q;
    if (tick) begin
      for (int i = 0; i < IO_DATA_W; i++) begin
        if (sample_q[i] == sample_prev_q[i]) deb_d[i] = sample_q[i];
      end
    end
  end
`else
  assign deb_d = sw_sync_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) deb_q <= '0;
    else        deb_q <= deb_d;
  end

  assign deb      = deb_q;
  assign deb_edge = deb_d ^ deb_q;

endmodule

// File: rtl/io_port_responder.sv
// Memory-mapped switch/LED responder on the simple_cpu data bus with change
// flags and a maskable interrupt. Optional debouncer: IO_PORT_DEBOUNCE_EN.
module io_port_responder
  import simple_cpu_pkg::*;
#(
  parameter int unsigned ADDR_W          = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  io_port_responder_if.slave   bus,
  input  logic [IO_DATA_W-1:0] sw,
  output logic [IO_DATA_W-1:0] led,
  output logic                 irq
);

  bus_state_t           state_q, state_d;
  logic [IO_DATA_W-1:0] led_q, led_d;
  logic [IO_DATA_W-1:0] chg_q, chg_d;
  logic [IO_DATA_W-1:0] irq_en_q, irq_en_d;
  logic [IO_DATA_W-1:0] rdata_q, rdata_d;
  logic                 irq_q;
  logic [IO_DATA_W-1:0] chg_clr;
  logic [IO_DATA_W-1:0] rd_mux;
  logic [IO_DATA_W-1:0] deb;
  logic [IO_DATA_W-1:0] deb_edge;

  io_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_deb (
    .clk      (clk),
    .rst_n    (rst_n),
    .sw       (sw),
    .deb      (deb),
    .deb_edge (deb_edge)
  );

  always_comb begin
    rd_mux = '0;
    case (bus.bus_addr)
      ADDR_W'(IO_ADDR_SW):     rd_mux = deb;
      ADDR_W'(IO_ADDR_LED):    rd_mux = led_q;
      ADDR_W'(IO_ADDR_CHG):    rd_mux = chg_q;
      ADDR_W'(IO_ADDR_IRQ_EN): rd_mux = irq_en_q;
      default:                 rd_mux = '0;
    endcase
  end

  // Requests are only accepted in IDLE; ACK always returns to IDLE without
  // looking at bus_req, which caps throughput at one transaction per 2 cycles.
  always_comb begin
    state_d  = state_q;
    led_d    = led_q;
    irq_en_d = irq_en_q;
    chg_clr  = '0;
    rdata_d  = '0;
    case (state_q)
      BUS_IDLE: begin
        if (bus.bus_req) begin
          state_d = BUS_ACK;
          if (bus.bus_we) begin
            case (bus.bus_addr)
              ADDR_W'(IO_ADDR_LED):    led_d    = bus.bus_wdata;
              ADDR_W'(IO_ADDR_CHG):    chg_clr  = bus.bus_wdata;
              ADDR_W'(IO_ADDR_IRQ_EN): irq_en_d = bus.bus_wdata;
              default:                 ;
            endcase
          end else begin
            rdata_d = rd_mux;
          end
        end
      end
      default: state_d = BUS_IDLE;
    endcase
    // A fresh edge beats a simultaneous write-1-to-clear.
    chg_d = (chg_q & ~chg_clr) | deb_edge;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= BUS_IDLE;
      led_q    <= '0;
      chg_q    <= '0;
      irq_en_q <= '0;
      rdata_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      led_q    <= led_d;
      chg_q    <= chg_d;
      irq_en_q <= irq_en_d;
      rdata_q  <= rdata_d;
      irq_q    <= |(chg_q & irq_en_q);
    end
  end

  assign bus.bus_ready = (state_q == BUS_ACK);
  assign bus.bus_rdata = rdata_q;
  assign led           = led_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_io_port_responder.sv
// Directed bench for io_port_responder; covers both IO_PORT_DEBOUNCE_EN builds.
module tb_io_port_responder;
  import simple_cpu_pkg::*;

  localparam int unsigned DB = 8;

  logic        clk;
  logic        rst_n;
  logic [15:0] sw;
  logic [15:0] led;
  logic        irq;
  logic [15:0] rd;
  int          n_checks;
  int          n_errors;

  io_port_responder_if #(.ADDR_W(4)) bus_if ();

  io_port_responder #(
    .ADDR_W          (4),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if),
    .sw    (sw),
    .led   (led),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Full transaction: ACK must be the very next cycle, then drop cleanly.
  task automatic xact(input logic we, input logic [3:0] addr, input logic [15:0] wd,
                      output logic [15:0] rdata);
    bus_if.bus_req   = 1'b1;
    bus_if.bus_we    = we;
    bus_if.bus_addr  = addr;
    bus_if.bus_wdata = wd;
    step(1);
    check("ack", bus_if.bus_ready, 16'd1);
    rdata = bus_if.bus_rdata;
    bus_if.bus_req = 1'b0;
    step(1);
    check("ack_drop", bus_if.bus_ready, 16'd0);
    check("rdata_idle", bus_if.bus_rdata, 16'h0000);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    sw               = 16'h00FF;
    rst_n            = 1'b0;
    bus_if.bus_req   = 1'b0;
    bus_if.bus_we    = 1'b0;
    bus_if.bus_addr  = '0;
    bus_if.bus_wdata = '0;

    step(3);
    check("rst_ready", bus_if.bus_ready, 16'd0);
    check("rst_rdata", bus_if.bus_rdata, 16'h0000);
    check("rst_led", led, 16'h0000);
    check("rst_irq", irq, 16'd0);
    rst_n = 1'b1;

`ifdef IO_PORT_DEBOUNCE_EN
    step(4 * DB + 4);
`else
    step(4);
`endif
    xact(1'b0, 4'h0, 16'h0, rd); check("sw_after_reset", rd, 16'h00FF);
    xact(1'b0, 4'h2, 16'h0, rd); check("chg_after_reset", rd, 16'h00FF);

    // LED write visible in the ACK cycle
    bus_if.bus_req = 1'b1; bus_if.bus_we = 1'b1;
    bus_if.bus_addr = 4'h1; bus_if.bus_wdata = 16'hA5A5;
    step(1);
    check("led_ack", bus_if.bus_ready, 16'd1);
    check("led_in_ack", led, 16'hA5A5);
    bus_if.bus_req = 1'b0;
    step(1);

    xact(1'b0, 4'h1, 16'h0, rd);    check("led_read", rd, 16'hA5A5);
    xact(1'b0, 4'h6, 16'h0, rd);    check("unmapped_read", rd, 16'h0000);
    xact(1'b1, 4'h6, 16'hFFFF, rd);
    xact(1'b1, 4'h0, 16'h1234, rd);
    xact(1'b0, 4'h1, 16'h0, rd);    check("led_kept", rd, 16'hA5A5);
    xact(1'b0, 4'h3, 16'h0, rd);    check("irq_en_kept", rd, 16'h0000);
    xact(1'b0, 4'h2, 16'h0, rd);    check("chg_kept", rd, 16'h00FF);
    xact(1'b0, 4'h0, 16'h0, rd);    check("sw_kept", rd, 16'h00FF);
    xact(1'b1, 4'h2, 16'hFFFF, rd);
    xact(1'b0, 4'h2, 16'h0, rd);    check("chg_cleared", rd, 16'h0000);
    xact(1'b1, 4'h3, 16'h0008, rd);
    check("irq_masked_idle", irq, 16'd0);

    sw = 16'h00F7;
`ifdef IO_PORT_DEBOUNCE_EN
    step(3 * DB + 4);
    check("irq_rise", irq, 16'd1);
    xact(1'b0, 4'h0, 16'h0, rd);    check("sw_held", rd, 16'h00F7);
`else
    // deb moves on the third edge after sw; a read captured on that edge sees the old value
    step(2);
    xact(1'b0, 4'h0, 16'h0, rd);    check("sw_not_yet", rd, 16'h00FF);
    check("irq_rise", irq, 16'd1);
    xact(1'b0, 4'h0, 16'h0, rd);    check("sw_3cyc", rd, 16'h00F7);
`endif
    xact(1'b0, 4'h2, 16'h0, rd);    check("chg3_set", rd, 16'h0008);

    // Clearing write: irq still high in ACK, low the cycle after
    bus_if.bus_req = 1'b1; bus_if.bus_we = 1'b1;
    bus_if.bus_addr = 4'h2; bus_if.bus_wdata = 16'h0008;
    step(1);
    check("irq_in_clear_ack", irq, 16'd1);
    bus_if.bus_req = 1'b0;
    step(1);
    check("irq_fall", irq, 16'd0);

`ifdef IO_PORT_DEBOUNCE_EN
    // Bounce shorter than one tick period must be filtered out
    sw = 16'h00FF;
    step(DB - 2);
    sw = 16'h00F7;
    step(4 * DB);
    xact(1'b0, 4'h2, 16'h0, rd);    check("glitch_chg", rd, 16'h0000);
    xact(1'b0, 4'h0, 16'h0, rd);    check("glitch_sw", rd, 16'h00F7);
`else
    // New sw[3] edge lands on the same edge as the W1C of bit 3: set wins
    sw = 16'h00FF;
    step(2);
    xact(1'b1, 4'h2, 16'h0008, rd);
    xact(1'b0, 4'h2, 16'h0, rd);    check("set_wins", rd, 16'h0008);
    check("set_wins_irq", irq, 16'd1);
    xact(1'b1, 4'h2, 16'hFFFF, rd);
`endif

    // req held across two transactions: ACK only on alternate cycles
    bus_if.bus_req = 1'b1; bus_if.bus_we = 1'b0; bus_if.bus_addr = 4'h1;
    step(1); check("b2b_ack0", bus_if.bus_ready, 16'd1);
    check("b2b_data0", bus_if.bus_rdata, 16'hA5A5);
    step(1); check("b2b_gap", bus_if.bus_ready, 16'd0);
    step(1); check("b2b_ack1", bus_if.bus_ready, 16'd1);
    check("b2b_data1", bus_if.bus_rdata, 16'hA5A5);
    bus_if.bus_req = 1'b0;
    step(1); check("b2b_end", bus_if.bus_ready, 16'd0);

    // Reset lands after a write request is presented in IDLE
    bus_if.bus_req = 1'b1; bus_if.bus_we = 1'b1;
    bus_if.bus_addr = 4'h1; bus_if.bus_wdata = 16'hFFFF;
    #2 rst_n = 1'b0;
    step(1);
    check("abort_ready", bus_if.bus_ready, 16'd0);
    check("abort_rdata", bus_if.bus_rdata, 16'h0000);
    check("abort_led", led, 16'h0000);
    check("abort_irq", irq, 16'd0);
    step(1);
    check("abort_ready2", bus_if.bus_ready, 16'd0);
    bus_if.bus_req = 1'b0;
    rst_n = 1'b1;
    step(1);
    xact(1'b0, 4'h1, 16'h0, rd);    check("abort_led_read", rd, 16'h0000);
    xact(1'b0, 4'h3, 16'h0, rd);    check("abort_irq_en", rd, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/io_port_responder.md
# io_port_responder

Memory-mapped I/O responder on the `simple_cpu` data bus; the target end of the CPU's load/store requests. It owns the board-facing switch inputs and LED outputs, synchronizes and debounces the switches, and latches per-bit change flags that can raise an interrupt. It sits between the CPU core and the `simple_cpu_basys3` pins, replacing direct `sw`/`led` wiring.

## Interface
- `ADDR_W`, 4: bus word-address width.
- `DEBOUNCE_CYCLES`, 100000: clock cycles between debounce samples; must be ≥2.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `bus_req`  in  1  transaction request; held high by the initiator until `bus_ready`.
- `bus_we`  in  1  1 = write, 0 = read; stable while `bus_req` is high.
- `bus_addr`  in  ADDR_W  word address; stable while `bus_req` is high.
- `bus_wdata`  in  16  write data.
- `bus_ready`  out  1  one-cycle completion pulse.
- `bus_rdata`  out  16  read data, valid only while `bus_ready` = 1.
- `sw`  in  16  raw asynchronous switch inputs.
- `led`  out  16  LED drive.
- `irq`  out  1  level interrupt.

## Operation
- Register map (word addresses):
  - 0x0 SW: read-only, debounced switch value; writes ignored.
  - 0x1 LED: read/write; drives `led`.
  - 0x2 CHG: per-bit change flags; read returns flags; write-1-to-clear.
  - 0x3 IRQ_EN: read/write mask.
  - 0x4–max: read 0; writes ignored; still acknowledged.
- Bus FSM, two states:
  - IDLE: `bus_ready` = 0. If `bus_req` = 1, perform the write, or capture the read data, then go to ACK.
  - ACK: `bus_ready` = 1 for exactly one cycle, then return to IDLE unconditionally.
  - `bus_req` is never sampled in ACK.
  - The initiator drops `bus_req`, or presents a new transaction, in the cycle after the ACK cycle.
  - Peak throughput is one transaction per 2 cycles.
- `bus_rdata` is 0 whenever `bus_ready` = 0.
- Input path: `sw` passes through a 2-flop synchronizer to `sw_sync`.
- Debounce:
  - A free-running prescaler counts 0..DEBOUNCE_CYCLES-1 and asserts `tick` on wrap.
  - On `tick`, `sample` ← `sw_sync` and `sample_prev` ← `sample`.
  - Per bit, `deb[i]` ← `sample[i]` when `sample[i]` == `sample_prev[i]`; otherwise `deb[i]` holds.
- Change flags:
  - `chg[i]` sets on any edge of `deb[i]`.
  - A W1C write clears the flags written as 1.
  - If set and clear hit the same bit in the same cycle, set wins.
- `irq` = |(`chg` & `irq_en`), registered.
- Reset values:
  - `bus_ready` = 0, `bus_rdata` = 0, `led` = 0, `irq` = 0.
  - `chg` = 0, `irq_en` = 0, `deb` = 0, sync/sample flops = 0, prescaler = 0, FSM = IDLE.
- Reset mid-transaction aborts it; no ACK is issued. The initiator must re-issue the request.

## Timing
- Write: effective at the clock edge leaving IDLE. `led` reflects the new value in the ACK cycle.
- Read: request seen in IDLE at cycle N; data returned with `bus_ready` in cycle N+1. Data is the register value sampled at the edge ending cycle N.
- `irq` lags its inputs by 1 cycle:
  - `irq` rises 1 cycle after `chg` & `irq_en` becomes nonzero.
  - `irq` falls 1 cycle after the clearing write's edge.
- Switch latency:
  - 2 cycles through the synchronizer.
  - Then 2 ticks minimum, 3 ticks maximum, until `deb` updates.
  - `chg` sets on the same edge as `deb`.
- A bounce shorter than one tick period never reaches `deb`.

## Configuration
- `IO_PORT_DEBOUNCE_EN`:
  - Defined: prescaler and sample stages are compiled in, as described above.
  - Undefined: `deb` ← `sw_sync` every cycle, with no prescaler; the `DEBOUNCE_CYCLES` parameter is unused. Total latency is 3 cycles from `sw` to `deb`/`chg`.

## Structure
- Shared package `simple_cpu_pkg` holds:
  - Register address constants `IO_ADDR_SW`, `IO_ADDR_LED`, `IO_ADDR_CHG`, `IO_ADDR_IRQ_EN`.
  - The bus FSM state typedef.
- One sub-module, `io_debounce`:
  - Contains the synchronizer, prescaler, and sample/compare logic.
  - Output is `deb`.
  - Keeps the bus/register logic separate.

## Test plan
- Reset with `sw` = 16'h00FF, release `rst_n`, wait 4 ticks → read 0x0 returns 16'h00FF with `bus_ready` exactly one cycle after request; `chg` = 16'h00FF.
- Write 0x1 = 16'hA5A5 → `led` = 16'hA5A5 in ACK cycle; read 0x1 → 16'hA5A5; read 0x6 → 16'h0000, and a write to 0x6 leaves all registers unchanged.
- Toggle `sw[3]` for fewer than DEBOUNCE_CYCLES cycles, then restore → `deb` and `chg` unchanged. A change held for 3 ticks → `chg[3]` = 1.
- `irq_en` = 16'h0008, `chg[3]` set → `irq` = 1. Write 0x2 = 16'h0008 → `irq` = 0 the cycle after the ACK cycle. Arrange a new `sw[3]` edge on the same cycle as the clear → `chg[3]` stays 1.
- Back-to-back requests with `bus_req` held high across two transactions → ACKs on alternate cycles only. Assert `rst_n` = 0 in IDLE-after-request → no `bus_ready`, and all outputs at reset values.
- Build without `IO_PORT_DEBOUNCE_EN` → a `sw` change appears in a read of 0x0 issued 3 cycles later.
